// File: rtl/bsg_chip_link_pkg.sv
// Shared types and helpers for the chip memory-command link: message types,
// size encoding, beat decode and flit-count arithmetic.
package bsg_chip_link_pkg;

  typedef enum logic [3:0] {
    e_mem_rd    = 4'd0,
    e_mem_wr    = 4'd1,
    e_mem_uc_rd = 4'd2,
    e_mem_uc_wr = 4'd3,
    e_mem_amo   = 4'd5
  } mem_msg_e;

  // A command of 2^size bytes
  typedef enum logic [2:0] {
    e_size_1B   = 3'd0,
    e_size_2B   = 3'd1,
    e_size_4B   = 3'd2,
    e_size_8B   = 3'd3,
    e_size_16B  = 3'd4,
    e_size_32B  = 3'd5,
    e_size_64B  = 3'd6,
    e_size_128B = 3'd7
  } mem_size_e;

  localparam int beats_width_gp = 5;

  function automatic logic [beats_width_gp-1:0] beats_from_size(input logic [3:0] msg_type,
                                                                input logic [2:0] size);
    logic carries_data;
    carries_data = (msg_type == e_mem_wr) || (msg_type == e_mem_uc_wr) || (msg_type == e_mem_amo);
    if (!carries_data)
      return '0;
    else if (size <= e_size_8B)
      return beats_width_gp'(1);
    else
      return beats_width_gp'(1) << (size - e_size_8B);
  endfunction

  function automatic int hdr_flits(input int header_width, input int link_width);
    return (header_width + link_width - 1) / link_width;
  endfunction

  function automatic int data_flits(input int dword_width, input int link_width);
    return dword_width / link_width;
  endfunction

endpackage

// File: rtl/bsg_chip_mem_header_decode.sv
// Combinational header decode: extracts type and size fields and returns the
// number of 64-bit data beats that follow the header. Shared with the rx side.
module bsg_chip_mem_header_decode
  import bsg_chip_link_pkg::*;
#(
  parameter int header_width_p = 72,
  parameter int msg_type_lsb_p = 0,
  parameter int size_lsb_p     = 4
) (
  input  logic [header_width_p-1:0] header_i,
  output logic [beats_width_gp-1:0] beats_o
);

  logic [3:0] msg_type;
  logic [2:0] size;
  logic       unused_hdr_bits;

  assign msg_type        = header_i[msg_type_lsb_p +: 4];
  assign size            = header_i[size_lsb_p +: 3];
  assign beats_o         = beats_from_size(msg_type, size);
  assign unused_hdr_bits = ^header_i;

endmodule

// File: rtl/bsg_chip_mem_cmd_link_tx.sv
// Serializes header + data beats into link flits; first flit valid 1 cycle after header accept.
// Link stalls hold the flit; upstream readies depend on state only, early data is held off.
module bsg_chip_mem_cmd_link_tx
  import bsg_chip_link_pkg::*;
#(
  parameter int header_width_p = 72,
  parameter int dword_width_p  = 64,
  parameter int link_width_p   = 16,
  parameter int msg_type_lsb_p = 0,
  parameter int size_lsb_p     = 4
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [header_width_p-1:0] mem_cmd_header_i,
  input  logic                      mem_cmd_header_v_i,
  output logic                      mem_cmd_header_ready_o,
  input  logic [dword_width_p-1:0]  mem_cmd_data_i,
  input  logic                      mem_cmd_data_v_i,
  output logic                      mem_cmd_data_ready_o,
  output logic [link_width_p-1:0]   link_data_o,
  output logic                      link_v_o,
  input  logic                      link_ready_i
);

  localparam int hf_lp        = hdr_flits(header_width_p, link_width_p);
  localparam int df_lp        = data_flits(dword_width_p, link_width_p);
  localparam int hdr_bits_lp  = hf_lp * link_width_p;
  localparam int sr_width_lp  = (hdr_bits_lp > dword_width_p) ? hdr_bits_lp : dword_width_p;
  localparam int max_flits_lp = (hf_lp > df_lp) ? hf_lp : df_lp;
  localparam int cnt_width_lp = $clog2(max_flits_lp + 1);

  typedef enum logic [1:0] {
    e_idle  = 2'd0,
    e_hdr   = 2'd1,
    e_dwait = 2'd2,
    e_dsend = 2'd3
  } state_e;

  state_e                    state_q, state_d;
  logic [sr_width_lp-1:0]    sr_q, sr_d;
  logic [cnt_width_lp-1:0]   cnt_q, cnt_d;
  logic [beats_width_gp-1:0] beats_q, beats_d;
  logic                      link_v_q, link_v_d;
  logic                      hdr_rdy_q, hdr_rdy_d;
  logic                      data_rdy_q, data_rdy_d;
  logic [beats_width_gp-1:0] hdr_beats;
  logic [beats_width_gp-1:0] beats_left;

  bsg_chip_mem_header_decode #(
    .header_width_p(header_width_p),
    .msg_type_lsb_p(msg_type_lsb_p),
    .size_lsb_p    (size_lsb_p)
  ) decode (
    .header_i(mem_cmd_header_i),
    .beats_o (hdr_beats)
  );

  assign beats_left = beats_q - beats_width_gp'(1);

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    beats_d = beats_q;
    unique case (state_q)
      e_idle: begin
        if (mem_cmd_header_v_i) begin
          sr_d    = sr_width_lp'(mem_cmd_header_i);
          beats_d = hdr_beats;
          cnt_d   = '0;
          state_d = e_hdr;
        end
      end
      e_hdr: begin
        if (link_ready_i) begin
          sr_d  = sr_q >> link_width_p;
          cnt_d = cnt_q + cnt_width_lp'(1);
          if (cnt_q == cnt_width_lp'(hf_lp - 1))
            state_d = (beats_q != '0) ? e_dwait : e_idle;
        end
      end
      e_dwait: begin
        if (mem_cmd_data_v_i) begin
          sr_d    = sr_width_lp'(mem_cmd_data_i);
          cnt_d   = '0;
          state_d = e_dsend;
        end
      end
      e_dsend: begin
        if (link_ready_i) begin
          sr_d  = sr_q >> link_width_p;
          cnt_d = cnt_q + cnt_width_lp'(1);
          if (cnt_q == cnt_width_lp'(df_lp - 1)) begin
            beats_d = beats_left;
            state_d = (beats_left != '0) ? e_dwait : e_idle;
          end
        end
      end
      default: state_d = e_idle;
    endcase

    // Outputs are registered copies of the next state's decode.
    link_v_d   = (state_d == e_hdr) || (state_d == e_dsend);
    hdr_rdy_d  = (state_d == e_idle);
    data_rdy_d = (state_d == e_dwait);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= e_idle;
      sr_q       <= '0;
      cnt_q      <= '0;
      beats_q    <= '0;
      link_v_q   <= 1'b0;
      hdr_rdy_q  <= 1'b1;
      data_rdy_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      beats_q    <= beats_d;
      link_v_q   <= link_v_d;
      hdr_rdy_q  <= hdr_rdy_d;
      data_rdy_q <= data_rdy_d;
    end
  end

  assign link_data_o            = sr_q[link_width_p-1:0];
  assign link_v_o               = link_v_q;
  assign mem_cmd_header_ready_o = hdr_rdy_q;
  assign mem_cmd_data_ready_o   = data_rdy_q;

endmodule

// File: tb/tb_bsg_chip_mem_cmd_link_tx.sv
// Bench for the memory-command link transmitter: directed scenarios plus
// randomized packets compared against a flit-list reference model.
module tb_bsg_chip_mem_cmd_link_tx;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [71:0] mem_cmd_header_i;
  logic        mem_cmd_header_v_i;
  logic        mem_cmd_header_ready_o;
  logic [63:0] mem_cmd_data_i;
  logic        mem_cmd_data_v_i;
  logic        mem_cmd_data_ready_o;
  logic [15:0] link_data_o;
  logic        link_v_o;
  logic        link_ready_i;

  int tests = 0;
  int fails = 0;

  always #5 clk_i = ~clk_i;

  bsg_chip_mem_cmd_link_tx dut (
    .clk_i                 (clk_i),
    .reset_i               (reset_i),
    .mem_cmd_header_i      (mem_cmd_header_i),
    .mem_cmd_header_v_i    (mem_cmd_header_v_i),
    .mem_cmd_header_ready_o(mem_cmd_header_ready_o),
    .mem_cmd_data_i        (mem_cmd_data_i),
    .mem_cmd_data_v_i      (mem_cmd_data_v_i),
    .mem_cmd_data_ready_o  (mem_cmd_data_ready_o),
    .link_data_o           (link_data_o),
    .link_v_o              (link_v_o),
    .link_ready_i          (link_ready_i)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    assert (act === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  // Beats follow from the command's byte count: 2^size bytes in 8-byte beats,
  // at least one, and only for the data-carrying types.
  function automatic int model_beats(input int typ, input int sz);
    int bytes;
    if (!(typ == 1 || typ == 3 || typ == 5)) return 0;
    bytes = 1 << sz;
    return (bytes <= 8) ? 1 : bytes / 8;
  endfunction

  // mode: 0 link always ready, 1 ready toggles, 2 random ready.
  // early: data valid from the header cycle. abort_beat: reset mid-beat.
  task automatic run_pkt(input int typ, input int sz, input int mode, input bit early,
                         input int abort_beat, input bit use_fixed, input logic [63:0] fixed_d);
    logic [79:0] hdr;
    logic [63:0] dw[$];
    logic [15:0] exp_q[$];
    logic [15:0] held;
    bit          stalled, tog, r, exp_dr;
    int          nb, acc, sh, sd, cyc;

    hdr = '0;
    hdr[31:0]  = $urandom;
    hdr[63:32] = $urandom;
    hdr[71:64] = 8'($urandom);
    hdr[3:0]   = 4'(typ);
    hdr[6:4]   = 3'(sz);
    nb = model_beats(typ, sz);
    for (int b = 0; b < nb; b++) dw.push_back((use_fixed && b == 0) ? fixed_d : {$urandom, $urandom});
    for (int i = 0; i < 5; i++) exp_q.push_back(hdr[16*i +: 16]);
    for (int b = 0; b < nb; b++)
      for (int j = 0; j < 4; j++) exp_q.push_back(dw[b][16*j +: 16]);

    check("hdr_ready_idle", mem_cmd_header_ready_o, 1);
    mem_cmd_header_i   = hdr[71:0];
    mem_cmd_header_v_i = 1'b1;
    mem_cmd_data_v_i   = early && nb > 0;
    mem_cmd_data_i     = (nb > 0) ? dw[0] : 64'h0;
    link_ready_i       = 1'b0;
    @(negedge clk_i);
    mem_cmd_header_v_i = 1'b0;
    mem_cmd_header_i   = 72'h0;
    cyc = 1; acc = 0; sh = 0; sd = 0; stalled = 0; tog = 0; held = '0;

    while (exp_q.size() > 0 && cyc < 2000) begin
      exp_dr = (sh == 5) && (sd == acc * 4) && (acc < nb);
      check("link_v", link_v_o, !exp_dr);
      check("data_ready", mem_cmd_data_ready_o, exp_dr);
      check("hdr_ready_busy", mem_cmd_header_ready_o, 0);
      if (link_v_o) begin
        if (stalled) check("flit_hold", link_data_o, held);
        check("flit", link_data_o, exp_q[0]);
      end
      if (abort_beat > 0 && acc == abort_beat && sd == (abort_beat - 1) * 4 + 2) begin
        reset_i = 1'b1; link_ready_i = 1'b0; mem_cmd_data_v_i = 1'b0;
        @(negedge clk_i);
        reset_i = 1'b0;
        check("abort_link_v", link_v_o, 0);
        check("abort_hdr_ready", mem_cmd_header_ready_o, 1);
        check("abort_data_ready", mem_cmd_data_ready_o, 0);
        @(negedge clk_i);
        return;
      end
      if (mode == 0) r = 1'b1;
      else if (mode == 1) begin r = ~tog; tog = ~tog; end
      else r = 1'($urandom_range(1, 0));
      link_ready_i = r;
      stalled = link_v_o && !r;
      held    = link_data_o;
      if (link_v_o && r) begin
        void'(exp_q.pop_front());
        if (sh < 5) sh++; else sd++;
      end
      if (acc < nb) begin
        mem_cmd_data_v_i = early ? 1'b1 : mem_cmd_data_ready_o;
        mem_cmd_data_i   = dw[acc];
      end else mem_cmd_data_v_i = 1'b0;
      if (mem_cmd_data_ready_o && mem_cmd_data_v_i) acc++;
      @(negedge clk_i);
      if (acc >= nb) mem_cmd_data_v_i = 1'b0;
      cyc++;
    end

    check("pkt_timeout", (cyc >= 2000), 0);
    mem_cmd_data_v_i = 1'b0;
    link_ready_i     = 1'b0;
    check("end_hdr_ready", mem_cmd_header_ready_o, 1);
    check("end_link_v", link_v_o, 0);
    check("end_data_ready", mem_cmd_data_ready_o, 0);
    check("data_handshakes", acc, nb);
    if (mode == 0) check("pkt_cycles", cyc, 1 + 5 + nb * 5);
  endtask

  initial begin
    reset_i = 1'b1;
    mem_cmd_header_i = '0; mem_cmd_header_v_i = 1'b0;
    mem_cmd_data_i = '0;   mem_cmd_data_v_i = 1'b0;
    link_ready_i = 1'b0;
    repeat (3) @(negedge clk_i);
    reset_i = 1'b0;
    @(negedge clk_i);
    check("rst_link_v", link_v_o, 0);
    check("rst_data_ready", mem_cmd_data_ready_o, 0);
    check("rst_hdr_ready", mem_cmd_header_ready_o, 1);

    run_pkt(0, 6, 0, 0, 0, 0, 64'h0);                       // read, 5 flits
    run_pkt(3, 3, 0, 0, 0, 1, 64'h0123_4567_89AB_CDEF);     // single-beat write
    run_pkt(1, 6, 1, 0, 0, 0, 64'h0);                       // 8 beats, toggling ready
    run_pkt(1, 4, 0, 1, 0, 0, 64'h0);                       // early data
    run_pkt(1, 6, 0, 1, 3, 0, 64'h0);                       // reset in beat 3
    run_pkt(0, 3, 0, 0, 0, 0, 64'h0);                       // read after reset
    run_pkt(5, 2, 0, 0, 0, 0, 64'h0);                       // amo, one beat
    run_pkt(2, 5, 0, 0, 0, 0, 64'h0);                       // uc_rd, no beats
    run_pkt(1, 7, 2, 1, 0, 0, 64'h0);                       // 16 beats, random ready

    for (int k = 0; k < 20; k++) begin
      int t;
      case ($urandom_range(4, 0))
        0: t = 0; 1: t = 1; 2: t = 2; 3: t = 3; default: t = 5;
      endcase
      run_pkt(t, int'($urandom_range(7, 0)), int'($urandom_range(2, 0)),
              1'($urandom_range(1, 0)), 0, 0, 64'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bsg_chip_mem_cmd_link_tx.md
# bsg_chip_mem_cmd_link_tx

Downstream neighbour of the single-core BlackParrot chip top. Consumes the chip's split memory-command stream (one header plus zero or more 64-bit data beats) and serializes each command into a packet of fixed-width flits on a narrow off-chip link. Header flits go first, then data flits. The flit stream carries no length field; the receiver recovers the length by decoding the header itself.

## Interface
- `header_width_p`, default 72: memory-command header width. The chip top overrides it with its `cce_mem_msg_header_width_lp`.
- `dword_width_p`, default 64: data beat width.
- `link_width_p`, default 16: flit width. Legal values are 8, 16, 32, 64; it must divide `dword_width_p`.
- `msg_type_lsb_p`, default 0: LSB of the 4-bit message-type field in the header.
- `size_lsb_p`, default 4: LSB of the 3-bit size field in the header.

Ports:
- `clk_i` in 1: the single clock.
- `reset_i` in 1: synchronous, active-high reset.
- `mem_cmd_header_i` in `header_width_p`: command header.
- `mem_cmd_header_v_i` in 1: header valid.
- `mem_cmd_header_ready_o` out 1: header accepted when both valid and ready are high.
- `mem_cmd_data_i` in `dword_width_p`: data beat.
- `mem_cmd_data_v_i` in 1: data valid.
- `mem_cmd_data_ready_o` out 1: data beat accepted when both valid and ready are high.
- `link_data_o` out `link_width_p`: flit.
- `link_v_o` out 1: flit valid.
- `link_ready_i` in 1: flit consumed when valid and ready are both high.

## Operation
- **Derived counts.**
  - HF = ceil(`header_width_p`/`link_width_p`) header flits per packet; 5 at the defaults.
  - DF = `dword_width_p`/`link_width_p` flits per data beat; 4 at the defaults.
- **Beat count from the header.**
  - Only message types wr, uc_wr and amo carry data; all other types give 0 beats.
  - For data-carrying types, size s (a command of 2^s bytes) gives 1 beat when s ≤ 3, otherwise 2^(s−3) beats (maximum 16).
- **Flit packing.**
  - The header is sent LSB-first, zero-padded to HF·`link_width_p` bits.
  - Each dword is sent LSB-first.
- **State machine.** Four states: IDLE, HDR, DWAIT, DSEND.
  - **IDLE:** `mem_cmd_header_ready_o`=1. On header accept:
    - latch the header into the shift register;
    - latch the beat count;
    - clear the flit counter;
    - go to HDR.
  - **HDR:** `link_v_o`=1 and `link_data_o` = low flit of the shift register. On each link handshake, shift and increment the counter. On the handshake of flit HF−1, go to DWAIT if beats > 0, else IDLE.
  - **DWAIT:** `mem_cmd_data_ready_o`=1. On data accept, load the dword into the shift register, clear the counter and go to DSEND.
  - **DSEND:** same output and shifting as HDR. On the handshake of flit DF−1, decrement the beat count, then go to DWAIT if beats remain, else IDLE.
- **Ready rules.**
  - `mem_cmd_data_ready_o` is 0 outside DWAIT. Data presented early is held off and never dropped.
  - `mem_cmd_header_ready_o` is 0 outside IDLE.
- Beats beyond the decoded count are not consumed; they remain for the next command's data phase. This case is an upstream protocol violation and is not checked.
- **Link hold rule.** While `link_v_o`=1 and `link_ready_i`=0, `link_data_o` holds stable.

## Timing
- **Reset values:** state=IDLE, `link_v_o`=0, `mem_cmd_data_ready_o`=0, `mem_cmd_header_ready_o`=1 in the first cycle after reset is released. Counters and beat count are 0.
- **Reset mid-packet:** the partial packet is abandoned and not resumed. The receiving side is reset together with this block.
- **Header latency:** header accepted in cycle t gives the first flit valid in cycle t+1.
- **Ready-to-valid:** no combinational path from `link_ready_i` to `link_v_o`.
- **Ready outputs:** both ready outputs are functions of state only; they do not depend on the corresponding valid input.
- **Throughput at full link readiness:**
  - HF cycles of header flits;
  - 1 DWAIT bubble per beat, then DF flit cycles per beat;
  - 1 IDLE cycle between packets.
- **Example, 8-beat write at the defaults:** 1 + 5 + 8·(1+4) = 46 cycles from header valid to the next header ready.

## Structure
- Package `bsg_chip_link_pkg` holds:
  - the message-type enum (rd=0, wr=1, uc_rd=2, uc_wr=3, amo=5);
  - the size encoding;
  - function `beats_from_size(type, size)`;
  - HF/DF helper functions.
- Sub-module `bsg_chip_mem_header_decode`, combinational: header in, beat count out. It is reused by the receive side.
- Shift-register width is max(HF·`link_width_p`, `dword_width_p`); one register serves both header and data.

## Test plan
1. **Read:** rd header, size 6 -> exactly 5 flits, no data accepted, `mem_cmd_header_ready_o`=1 on the cycle after the 5th handshake.
2. **Single-beat write:** uc_wr, size 3, data 0x0123_4567_89AB_CDEF -> 5 header flits, then 0xCDEF, 0x89AB, 0x4567, 0x0123.
3. **Back-pressure:** wr, size 6 (8 beats) with `link_ready_i` toggling 1,0,1,0 -> 5+32 flits in order; each flit stable while stalled; exactly 8 data handshakes.
4. **Early data:** `mem_cmd_data_v_i`=1 from the header cycle onward -> `mem_cmd_data_ready_o` stays 0 until the cycle after the 5th header flit, then the data is accepted.
5. **Reset mid-packet:** assert `reset_i` during DSEND beat 3 of 8 -> next cycle `link_v_o`=0 and `mem_cmd_header_ready_o`=1; a new rd packet then serializes correctly.
6. **AMO:** amo, size 2 -> one data beat (4 flits). Then uc_rd -> zero data beats.
